// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// Optional macro I2C_NACK_ABORT_EN: an address NACK jumps straight to STOP.
module i2c_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata,
  output logic       scl,
  output logic       sda_out,
  input  logic       sda_in
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ACK1, S_WRITE, S_READ, S_ACK2, S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic [6:0]       addr_q;
  logic             rw_q;
  logic [7:0]       wdata_q;
  logic [6:0]       rd_sh_q;
  logic [7:0]       tx_byte;
  logic             qtr_end, step_end, sample, accept;
  logic             scl_d, sda_d;

  // Line levels for a given step position; q[1] marks the SCL-high half of a step.
  function automatic logic [1:0] line_levels(input state_t st, input logic [1:0] q,
                                             input logic tx_bit);
    logic hi;
    hi = q[1];
    case (st)
      S_IDLE:          return 2'b11;
      S_START:         return {1'b1, ~hi};
      S_ADDR, S_WRITE: return {hi, tx_bit};
      S_STOP:          return {hi, q == 2'd3};
      default:         return {hi, 1'b1};
    endcase
  endfunction

  assign qtr_end  = (div_q == DIV_MAX);
  assign step_end = qtr_end && (qtr_q == 2'd3);
  assign sample   = qtr_end && (qtr_q == 2'd2);
  assign accept   = start && (!busy || (state_q == S_STOP && step_end));

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    if (state_q != S_IDLE) begin
      div_d = qtr_end ? '0 : div_q + 1'b1;
      if (qtr_end) qtr_d = qtr_q + 2'd1;
      if (step_end) begin
        bit_d = '0;
        case (state_q)
          S_START: state_d = S_ADDR;
          S_ADDR: begin
            if (bit_q == 3'd7) state_d = S_ACK1;
            else               bit_d   = bit_q + 3'd1;
          end
          S_ACK1: begin
`ifdef I2C_NACK_ABORT_EN
            state_d = ack_err ? S_STOP : (rw_q ? S_READ : S_WRITE);
`else
            state_d = rw_q ? S_READ : S_WRITE;
`endif
          end
          S_WRITE, S_READ: begin
            if (bit_q == 3'd7) state_d = S_ACK2;
            else               bit_d   = bit_q + 3'd1;
          end
          S_ACK2:  state_d = S_STOP;
          default: state_d = S_IDLE;
        endcase
      end
    end
    if (accept) begin
      state_d = S_START;
      div_d   = '0;
      qtr_d   = '0;
      bit_d   = '0;
    end
  end

  // Lines are registered from the next-state position so they never glitch.
  always_comb begin
    tx_byte        = (state_d == S_ADDR) ? {addr_q, rw_q} : wdata_q;
    {scl_d, sda_d} = line_levels(state_d, qtr_d, tx_byte[3'd7 - bit_d]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= '0;
      scl     <= 1'b1;
      sda_out <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      busy    <= (state_d != S_IDLE);
      done    <= (state_q == S_STOP) && step_end;
      scl     <= scl_d;
      sda_out <= sda_d;
      if (accept)
        ack_err <= 1'b0;
      else if (sample && sda_in && (state_q == S_ACK1 || (state_q == S_ACK2 && !rw_q)))
        ack_err <= 1'b1;
      if (sample && state_q == S_READ && bit_q == 3'd7)
        rdata <= {rd_sh_q, sda_in};
    end
  end

  // Command and shift data carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= addr;
      rw_q    <= rw;
      wdata_q <= wdata;
    end
    if (sample && state_q == S_READ)
      rd_sh_q <= {rd_sh_q[5:0], sda_in};
  end

endmodule
